sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Parametrised synchronous FIFO with internal read/write pointers, occupancy tracking and status flags. It supersedes the externally-pointered 8x16 register buffer: callers only assert wr_en/rd_en, and the block owns all addressing. It sits between producer and consumer datapaths in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 4, pointer width; DEPTH = 2**ADDR_W entries (default 16)
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read request
rd_data  out  DATA_W  registered read data
rd_valid  out  1  rd_data holds a newly popped word this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (clk = clk, reset = reset, synchronous, active-high): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Storage array is not cleared. Flags follow from count=0: empty=1, almost_empty=1, full=0, almost_full=0.
- Flags are combinational from the registered count. They are valid the cycle after the edge that updates count.
- Write acceptance: wr_acc = wr_en & (~full | rd_en). On wr_acc, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read acceptance: rd_acc = rd_en & ~empty. On rd_acc, rd_data <= mem[rd_ptr] and rd_ptr increments. rd_valid = 1 on the following cycle only.
- Read latency: 1 clock from the rd_en edge to rd_data/rd_valid.
- With no accepted read, rd_data holds its last value and rd_valid = 0.
- Pointers wrap modulo DEPTH. Natural ADDR_W-bit rollover is used, with no extra logic.
- count update: +1 if wr_acc & ~rd_acc; -1 if rd_acc & ~wr_acc; unchanged otherwise.
- Simultaneous read and write:
  - when full: both are accepted, count stays DEPTH, and no overflow is signalled.
  - when empty: the write is accepted, the read is rejected (underflow pulses), and count becomes 1.
  - otherwise: both are accepted and count is unchanged.
- overflow pulses the cycle after wr_en & ~wr_acc. underflow pulses the cycle after rd_en & ~rd_acc. Neither error corrupts state.
- Reset asserted mid-stream: all in-flight words are discarded and the block returns to the reset state on that edge. Reset has priority over wr_en/rd_en.
- Parameter legality: 0 <= AE_LEVEL < AF_LEVEL <= DEPTH. This is checked at elaboration.

Optional Feature:
Macro SYNC_FIFO_WATERMARK_EN.
- Defined: adds output max_count [ADDR_W:0], the peak value of count since reset.
  - Updated on the same edge as count: max_count <= max(max_count, next count).
  - Reset value is 0.
  - Also adds input wm_clr (1 bit); when high, max_count <= next count.
- Undefined: neither the port nor the logic exists, and the rest of the behaviour is identical.

Test Plan:
- Reset, then write 0x01..0x10 on 16 consecutive cycles -> full=1, count=16, almost_full asserted after the 12th write; a 17th write of 0xAA -> overflow pulses once, count stays 16.
- From full, read 16 times -> rd_data 0x01..0x10 in order, each 1 cycle after rd_en with rd_valid=1; then empty=1; a further read -> underflow pulse, rd_data holds 0x10.
- Wrap: write 10, read 10, write 10, read 10 with values 0x20..0x33 -> exact order preserved across the pointer wrap; count returns to 0.
- Simultaneous: at count=16, wr_en=rd_en=1 with wr_data=0x55 -> count stays 16, no overflow, 0x55 is read out last. At count=0, same stimulus -> count=1, underflow pulse, next read returns 0x55.
- Reset mid-stream at count=7 -> next cycle count=0, empty=1, rd_data=0, rd_valid=0; a subsequent write of 0x99 then read -> returns 0x99.
- SYNC_FIFO_WATERMARK_EN defined: fill to 9, drain to 3 -> max_count=9; pulse wm_clr -> max_count=3.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO with owned pointers, occupancy count and status flags.
// Optional peak-occupancy watermark enabled by SYNC_FIFO_WATERMARK_EN.
module sync_fifo_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
`ifdef SYNC_FIFO_WATERMARK_EN
    ,
    input  logic              wm_clr,
    output logic [ADDR_W:0]   max_count
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W+1)'(AE_LEVEL);

    if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
        $error("sync_fifo_ctrl: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic [ADDR_W:0]   count_nxt;

    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A read frees the slot a write to a full FIFO needs, on the same edge
    assign wr_acc = wr_en & (~full | rd_en);
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc)
            count_nxt = count + 1'b1;
        else if (rd_acc && !wr_acc)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            rd_valid  <= rd_acc;
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & ~rd_acc;
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_WATERMARK_EN
    always_ff @(posedge clk) begin
        if (reset)
            max_count <= '0;
        else if (wm_clr || count_nxt > max_count)
            max_count <= count_nxt;
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl.
// Covers fill/drain, flags, errors, wrap, simultaneous access and reset.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
`ifdef SYNC_FIFO_WATERMARK_EN
    logic       wm_clr;
    logic [4:0] max_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef SYNC_FIFO_WATERMARK_EN
        ,
        .wm_clr       (wm_clr),
        .max_count    (max_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        rd_en   = 1'b0;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        rd_en = 1'b1;
        wr_en = 1'b0;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
`ifdef SYNC_FIFO_WATERMARK_EN
        wm_clr  = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;

        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_rdata", 32'(rd_data), 32'd0);
        check("rst_rvalid", 32'(rd_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_udf", 32'(underflow), 32'd0);

        // fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            check("fill_count", 32'(count), 32'(i));
            check("fill_af", 32'(almost_full), 32'(i >= 12));
            check("fill_ae", 32'(almost_empty), 32'(i <= 2));
            check("fill_empty", 32'(empty), 32'd0);
        end
        check("full_flag", 32'(full), 32'd1);

        push(8'hAA);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        tick();
        check("ovf_clear", 32'(overflow), 32'd0);

        for (int i = 1; i <= 16; i++) begin
            pop("drain", 8'(i));
            check("drain_count", 32'(count), 32'(16 - i));
        end
        tick();
        check("drain_rvalid_low", 32'(rd_valid), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);

        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("udf_pulse", 32'(underflow), 32'd1);
        check("udf_rvalid", 32'(rd_valid), 32'd0);
        check("udf_hold", 32'(rd_data), 32'h10);
        tick();
        check("udf_clear", 32'(underflow), 32'd0);

        // pointers cross the top of the array in the second batch
        for (int i = 0; i < 10; i++) push(8'(8'h20 + i));
        for (int i = 0; i < 10; i++) pop("wrap1", 8'(8'h20 + i));
        for (int i = 10; i < 20; i++) push(8'(8'h20 + i));
        check("wrap_count10", 32'(count), 32'd10);
        for (int i = 10; i < 20; i++) pop("wrap2", 8'(8'h20 + i));
        check("wrap_count0", 32'(count), 32'd0);

        // simultaneous access while full
        for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
        check("sim_full_pre", 32'(full), 32'd1);
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("sim_full_count", 32'(count), 32'd16);
        check("sim_full_ovf", 32'(overflow), 32'd0);
        check("sim_full_rdata", 32'(rd_data), 32'h60);
        check("sim_full_rvalid", 32'(rd_valid), 32'd1);
        for (int i = 1; i < 16; i++) pop("sim_drain", 8'(8'h60 + i));
        pop("sim_last", 8'h55);
        check("sim_empty", 32'(empty), 32'd1);

        // simultaneous access while empty
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("sim_empty_count", 32'(count), 32'd1);
        check("sim_empty_udf", 32'(underflow), 32'd1);
        check("sim_empty_rvalid", 32'(rd_valid), 32'd0);
        pop("sim_empty_read", 8'h55);

        // reset mid-stream with requests pending
        for (int i = 0; i < 7; i++) push(8'(8'h70 + i));
        check("mid_count7", 32'(count), 32'd7);
        pop("mid_pre", 8'h70);
        reset   = 1'b1;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'hEE;
        tick();
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("mid_count", 32'(count), 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        check("mid_rdata", 32'(rd_data), 32'd0);
        check("mid_rvalid", 32'(rd_valid), 32'd0);
        push(8'h99);
        pop("mid_after", 8'h99);

`ifdef SYNC_FIFO_WATERMARK_EN
        check("wm_after_reset", 32'(max_count), 32'd1);
        for (int i = 0; i < 9; i++) push(8'(i));
        for (int i = 0; i < 6; i++) pop("wm_drain", 8'(i));
        check("wm_count3", 32'(count), 32'd3);
        check("wm_peak", 32'(max_count), 32'd9);
        wm_clr = 1'b1;
        tick();
        wm_clr = 1'b0;
        check("wm_clr", 32'(max_count), 32'd3);
        push(8'hC0);
        check("wm_regrow", 32'(max_count), 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
